// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war round controller.
package tug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PLAY  = 2'd2,
    ST_CHEER = 2'd3
  } tug_state_e;

  localparam int unsigned SCORE_W = 7;

  localparam logic [2:0] POS_MIN    = 3'd0;
  localparam logic [2:0] POS_CENTER = 3'd3;
  localparam logic [2:0] POS_MAX    = 3'd6;

  // Foul penalties saturate one step short of a win.
  localparam logic [2:0] POS_FOUL_LO = 3'd1;
  localparam logic [2:0] POS_FOUL_HI = 3'd5;

  function automatic logic [SCORE_W-1:0] pos_to_score(input logic [2:0] p);
    return SCORE_W'(1) << p;
  endfunction

endpackage

// File: rtl/slow_tick_cnt.sv
// Clearable counter of slow-enable ticks with terminal-count detect.
// done fires on the tick that brings the count up to term.
module slow_tick_cnt
  import tug_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] cnt,
  output logic          done
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment; holds at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign done = inc && ((cnt_q + CW'(1)) == term);

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war round controller: IDLE -> COUNT -> PLAY -> CHEER -> IDLE.
// Optional feature macro: TUG_FALSE_START_EN (pushes during COUNT are fouls).
module tug_referee
  import tug_pkg::*;
#(
  parameter int unsigned COUNT_TICKS = 3,
  parameter int unsigned CHEER_TICKS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slowen,
  input  logic               start,
  input  logic               pbl,
  input  logic               pbr,
  output logic [SCORE_W-1:0] score,
  output logic               wingame,
  output logic [1:0]         winner,
  output logic               cheer_en,
  output logic               busy
);

  localparam int unsigned TICK_MAX = (COUNT_TICKS > CHEER_TICKS) ? COUNT_TICKS : CHEER_TICKS;
  localparam int unsigned CW       = $clog2(TICK_MAX) + 1;

  tug_state_e          state_q, state_d;
  logic [2:0]          pos_q, pos_d;
  logic [SCORE_W-1:0]  score_q;
  logic                wingame_q, wingame_d;
  logic [1:0]          winner_q, winner_d;
  logic                cheer_en_q;
  logic                busy_q;

  logic                tick_clr, tick_inc, tick_done;
  logic [CW-1:0]       tick_term, tick_cnt;

  slow_tick_cnt #(.CW(CW)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .inc  (tick_inc),
    .term (tick_term),
    .cnt  (tick_cnt),
    .done (tick_done)
  );

  // Next-state, rope position and win detection.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    wingame_d = 1'b0;
    winner_d  = winner_q;
    tick_inc  = 1'b0;
    tick_term = CW'(COUNT_TICKS);
    unique case (state_q)
      ST_IDLE: begin
        pos_d = POS_CENTER;
        if (start)
          state_d = ST_COUNT;
      end
      ST_COUNT: begin
        tick_inc  = slowen;
        tick_term = CW'(COUNT_TICKS);
`ifdef TUG_FALSE_START_EN
        if (pbl && !pbr)
          pos_d = (pos_q >= POS_FOUL_HI) ? POS_FOUL_HI : pos_q + 3'd1;
        else if (pbr && !pbl)
          pos_d = (pos_q <= POS_FOUL_LO) ? POS_FOUL_LO : pos_q - 3'd1;
`endif
        if (tick_done)
          state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (pbl && !pbr)
          pos_d = pos_q - 3'd1;
        else if (pbr && !pbl)
          pos_d = pos_q + 3'd1;
        if (pos_d == POS_MIN) begin
          state_d   = ST_CHEER;
          wingame_d = 1'b1;
          winner_d  = 2'b01;
        end else if (pos_d == POS_MAX) begin
          state_d   = ST_CHEER;
          wingame_d = 1'b1;
          winner_d  = 2'b10;
        end
      end
      ST_CHEER: begin
        tick_inc  = slowen;
        tick_term = CW'(CHEER_TICKS);
        if (tick_done) begin
          state_d = ST_IDLE;
          pos_d   = POS_CENTER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state change restarts the tick count, so an entry-edge tick is dropped.
    tick_clr = (state_d != state_q);
  end

  // State and registered outputs; outputs are computed from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pos_q      <= POS_CENTER;
      score_q    <= pos_to_score(POS_CENTER);
      wingame_q  <= 1'b0;
      winner_q   <= 2'b00;
      cheer_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      score_q    <= pos_to_score(pos_d);
      wingame_q  <= wingame_d;
      winner_q   <= winner_d;
      cheer_en_q <= (state_d == ST_CHEER);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign score    = score_q;
  assign wingame  = wingame_q;
  assign winner   = winner_q;
  assign cheer_en = cheer_en_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tug_referee.sv
// Directed self-checking bench for tug_referee (default parameters).
module tb_tug_referee;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slowen = 1'b0;
  logic       start = 1'b0;
  logic       pbl = 1'b0;
  logic       pbr = 1'b0;
  logic [6:0] score;
  logic       wingame;
  logic [1:0] winner;
  logic       cheer_en;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned wg_pulses = 0;

  tug_referee #(.COUNT_TICKS(3), .CHEER_TICKS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .slowen   (slowen),
    .start    (start),
    .pbl      (pbl),
    .pbr      (pbr),
    .score    (score),
    .wingame  (wingame),
    .winner   (winner),
    .cheer_en (cheer_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Count wingame pulses seen at each active edge.
  always @(posedge clk) if (wingame === 1'b1) wg_pulses <= wg_pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic step(input logic s, input logic sl, input logic l, input logic r);
    start = s; slowen = sl; pbl = l; pbr = r;
    @(posedge clk);
    #1;
    start = 1'b0; slowen = 1'b0; pbl = 1'b0; pbr = 1'b0;
  endtask

  function automatic logic [6:0] sc(input int p);
    logic [6:0] one;
    one = 7'd1;
    return one << p;
  endfunction

  int exp_pos;

  initial begin
    // Reset
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    check("rst_score", score, 7'b0001000);
    check("rst_busy", busy, 0);
    check("rst_wingame", wingame, 0);
    check("rst_winner", winner, 2'b00);
    check("rst_cheer", cheer_en, 0);

    // Pushes in IDLE ignored
    step(0, 0, 1, 0);
    check("idle_pbl", score, 7'b0001000);
    step(0, 0, 0, 1);
    check("idle_pbr", score, 7'b0001000);
    check("idle_busy", busy, 0);

    // Round 1: left wins
    step(1, 0, 0, 0);
    check("r1_start_busy", busy, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);              // third tick -> PLAY
    check("r1_play_score", score, 7'b0001000);
    step(1, 0, 1, 0);              // start ignored outside IDLE
    check("r1_pbl1", score, 7'b0000100);
    step(0, 0, 1, 0);
    check("r1_pbl2", score, 7'b0000010);
    check("r1_no_win_yet", wingame, 0);
    step(0, 0, 1, 0);
    check("r1_pbl3", score, 7'b0000001);
    check("r1_wingame", wingame, 1);
    check("r1_winner", winner, 2'b01);
    check("r1_cheer", cheer_en, 1);
    step(0, 0, 0, 1);              // push in CHEER ignored
    check("r1_wingame_drop", wingame, 0);
    check("r1_cheer_push", score, 7'b0000001);
    for (int unsigned i = 0; i < 7; i++) step(0, 1, 0, 0);
    check("r1_cheer_7", cheer_en, 1);
    check("r1_busy_7", busy, 1);
    step(0, 1, 0, 0);
    check("r1_cheer_done", cheer_en, 0);
    check("r1_idle_busy", busy, 0);
    check("r1_idle_score", score, 7'b0001000);
    check("r1_winner_held", winner, 2'b01);
    check("r1_pulses", wg_pulses, 1);

    // Round 2: tick coincident with start not counted; fouls; cancel; reset mid-play
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);              // still COUNT (only 2 ticks counted)
`ifdef TUG_FALSE_START_EN
    exp_pos = 2;
`else
    exp_pos = 3;
`endif
    check("r2_count_pbr", score, sc(exp_pos));
    check("r2_count_busy", busy, 1);
    step(0, 1, 0, 0);              // third counted tick -> PLAY
    step(0, 0, 1, 1);
    check("r2_cancel", score, sc(exp_pos));
    step(0, 0, 0, 1);
    exp_pos++;
`ifdef TUG_FALSE_START_EN
    check("r2_pbr", score, 7'b0001000);
`else
    check("r2_pbr", score, 7'b0010000);
`endif
    while (exp_pos < 5) begin
      step(0, 0, 0, 1);
      exp_pos++;
      check("r2_walk", score, sc(exp_pos));
    end
    check("r2_pos5", score, 7'b0100000);
    rst = 1'b1;
    step(0, 0, 0, 1);              // would be a right win without reset
    rst = 1'b0;
    check("r2_rst_score", score, 7'b0001000);
    check("r2_rst_busy", busy, 0);
    check("r2_rst_wingame", wingame, 0);
    check("r2_rst_winner", winner, 2'b00);
    step(0, 0, 0, 0);
    check("r2_pulses", wg_pulses, 1);

    // Round 3: right wins
    step(1, 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("r3_pos5", score, 7'b0100000);
    step(0, 0, 0, 1);
    check("r3_score", score, 7'b1000000);
    check("r3_wingame", wingame, 1);
    check("r3_winner", winner, 2'b10);
    step(0, 0, 0, 0);
    check("r3_pulses", wg_pulses, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
